// File: rtl/mem_responder.sv
// Fixed-latency memory responder serving one fetch or load/store at a time from a single-ported word array.
// Optional macro MEM_BOUNDS_CHECK_EN: flag and suppress accesses beyond the array depth.
module mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction_addr,
  input  logic        instruction_req,
  output logic [31:0] instruction_read,
  output logic        instruction_ready,
  input  logic [31:0] data_addr,
  input  logic        data_read_valid,
  input  logic        data_write_valid,
  input  logic [3:0]  data_write_byte,
  input  logic [31:0] data_write,
  output logic [31:0] data_read,
  output logic        data_ready,
  output logic        access_error
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic                  is_data;
    logic                  is_write;
    logic                  oob;
    logic [ADDR_WIDTH-1:0] idx;
    logic [3:0]            strb;
    logic [31:0]           wdata;
  } req_t;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  req_t        live, cap, acc;
  logic [31:0] mem [DEPTH];
  logic [31:0] rd_word;
  logic        data_req, any_req, do_access;
  logic        unused_bits;

  assign data_req = data_read_valid | data_write_valid;
  assign any_req  = data_req | instruction_req;
  assign unused_bits = ^{data_addr[1:0], instruction_addr[1:0],
                         data_addr[31:ADDR_WIDTH+2], instruction_addr[31:ADDR_WIDTH+2]};

  // Arbitration: data beats fetch; a store wins when both load and store are raised.
  always_comb begin
    live          = '0;
    live.is_data  = data_req;
    live.is_write = data_write_valid;
    live.strb     = data_write_byte;
    live.wdata    = data_write;
    if (data_req) begin
      live.idx = data_addr[ADDR_WIDTH+1:2];
`ifdef MEM_BOUNDS_CHECK_EN
      live.oob = |data_addr[31:ADDR_WIDTH+2];
`else
      live.oob = 1'b0;
`endif
    end else begin
      live.idx = instruction_addr[ADDR_WIDTH+1:2];
`ifdef MEM_BOUNDS_CHECK_EN
      live.oob = |instruction_addr[31:ADDR_WIDTH+2];
`else
      live.oob = 1'b0;
`endif
    end
  end

  // With LATENCY=1 the access happens on the accept edge, straight from the live request.
  assign acc       = (state == IDLE) ? live : cap;
  assign do_access = (state == BUSY && cnt == '0) || (LATENCY == 1 && state == IDLE && any_req);
  assign rd_word   = acc.oob ? '0 : mem[acc.idx];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = (LATENCY == 1) ? DONE : BUSY;
      BUSY:    if (cnt == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) begin
        cnt <= CNT_INIT;
        cap <= live;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Reset on the commit edge blocks the write.
  always_ff @(posedge clk) begin
    if (!reset && do_access && acc.is_data && acc.is_write && !acc.oob)
      for (int i = 0; i < 4; i++)
        if (acc.strb[i]) mem[acc.idx][8*i +: 8] <= acc.wdata[8*i +: 8];
  end

  // Stores also return the pre-write word; read data holds until the port's next response.
  always_ff @(posedge clk) begin
    if (reset) begin
      instruction_read  <= '0;
      data_read         <= '0;
      instruction_ready <= 1'b0;
      data_ready        <= 1'b0;
      access_error      <= 1'b0;
    end else begin
      instruction_ready <= 1'b0;
      data_ready        <= 1'b0;
      access_error      <= 1'b0;
      if (do_access) begin
        access_error <= acc.oob;
        if (acc.is_data) begin
          data_ready <= 1'b1;
          data_read  <= rd_word;
        end else begin
          instruction_ready <= 1'b1;
          instruction_read  <= rd_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: drivers push expected responses, a negedge monitor pops and compares.
module tb_mem_responder;
  localparam int AW  = 10;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction_addr = '0;
  logic        instruction_req = 1'b0;
  logic [31:0] instruction_read;
  logic        instruction_ready;
  logic [31:0] data_addr = '0;
  logic        data_read_valid = 1'b0;
  logic        data_write_valid = 1'b0;
  logic [3:0]  data_write_byte = '0;
  logic [31:0] data_write = '0;
  logic [31:0] data_read;
  logic        data_ready;
  logic        access_error;

  mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .instruction_addr(instruction_addr), .instruction_req(instruction_req),
    .instruction_read(instruction_read), .instruction_ready(instruction_ready),
    .data_addr(data_addr), .data_read_valid(data_read_valid),
    .data_write_valid(data_write_valid), .data_write_byte(data_write_byte),
    .data_write(data_write), .data_read(data_read), .data_ready(data_ready),
    .access_error(access_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit          is_data;
    bit          chk;
    logic [31:0] data;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   n_resp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Ready is expected in the cycle after edge accept+LAT, i.e. the monitor sees cyc == accept+LAT.
  always @(negedge clk) begin
    if (!reset && (data_ready || instruction_ready)) begin
      exp_t e;
      logic [31:0] act;
      n_resp++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_ready: got d=%0b i=%0b at cyc %0d, expected none", data_ready, instruction_ready, cyc);
      end else begin
        e = exp_q.pop_front();
        act = e.is_data ? data_read : instruction_read;
        if (data_ready !== e.is_data || instruction_ready !== !e.is_data ||
            (e.chk && act !== e.data) || access_error !== e.err || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL response: got d_rdy=%0b i_rdy=%0b data=%h err=%0b cyc=%0d, expected data_port=%0b data=%h(chk %0b) err=%0b cyc=%0d",
                   data_ready, instruction_ready, act, access_error, cyc, e.is_data, e.data, e.chk, e.err, e.cyc);
        end
      end
    end
  end

  task automatic push(input bit is_data, input bit c, input logic [31:0] d, input bit err, input int acc_cyc);
    exp_t e;
    e.is_data = is_data; e.chk = c; e.data = d; e.err = err; e.cyc = acc_cyc + LAT;
    exp_q.push_back(e);
  endtask

  task automatic drop_all();
    instruction_req = 1'b0; data_read_valid = 1'b0; data_write_valid = 1'b0;
  endtask

  // One transaction from IDLE; returns on edge accept+LAT+1 so the next drive lands in IDLE.
  task automatic xact(input bit fetch, input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [3:0] strb, input logic [31:0] wd,
                      input bit c, input logic [31:0] d, input bit err);
    @(negedge clk);
    if (fetch) begin
      instruction_req = 1'b1; instruction_addr = addr;
    end else begin
      data_read_valid = rd; data_write_valid = wr; data_addr = addr;
      data_write_byte = strb; data_write = wd;
    end
    @(posedge clk); #1;
    push(!fetch, c, d, err, cyc);
    drop_all();
    repeat (LAT + 1) @(posedge clk);
  endtask

  task automatic reset_mid(input logic [31:0] addr, input logic [31:0] wd, input int k, input string name);
    int n0;
    n0 = n_resp;
    @(negedge clk);
    data_write_valid = 1'b1; data_addr = addr; data_write_byte = 4'hF; data_write = wd;
    @(posedge clk); #1;
    drop_all();
    repeat (k - 1) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (LAT + 3) @(posedge clk);
    @(negedge clk);
    chk({name, "_no_ready"}, n_resp, n0);
    chk({name, "_data_read_cleared"}, data_read, 32'h0);
  endtask

  initial begin : stim
    int t0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_instruction_read", instruction_read, 32'h0);
    chk("rst_data_read", data_read, 32'h0);
    chk("rst_instruction_ready", {31'b0, instruction_ready}, 32'h0);
    chk("rst_data_ready", {31'b0, data_ready}, 32'h0);
    chk("rst_access_error", {31'b0, access_error}, 32'h0);
    reset = 1'b0;

    // Seed words; pre-write contents are unknown so data is not checked.
    xact(0, 0, 1, 32'h20, 4'hF, 32'hCAFEF00D, 0, 32'h0, 0);
    xact(0, 0, 1, 32'h00, 4'hF, 32'h0BADC0DE, 0, 32'h0, 0);
    xact(0, 0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, 32'h0, 0);
    xact(0, 1, 0, 32'h10, 4'h0, 32'h0,        1, 32'hDEADBEEF, 0);
    // Byte-lane store; the store response carries the old word.
    xact(0, 0, 1, 32'h10, 4'b0010, 32'h0000AA00, 1, 32'hDEADBEEF, 0);
    xact(0, 1, 0, 32'h10, 4'h0, 32'h0,           1, 32'hDEADAAEF, 0);
    // Zero strobes leave the word alone.
    xact(0, 0, 1, 32'h10, 4'b0000, 32'hFFFFFFFF, 1, 32'hDEADAAEF, 0);
    xact(0, 1, 0, 32'h10, 4'h0, 32'h0,           1, 32'hDEADAAEF, 0);
    // Load and store together act as a store.
    xact(0, 1, 1, 32'h10, 4'b1100, 32'h12340000, 1, 32'hDEADAAEF, 0);
    xact(0, 1, 0, 32'h13, 4'h0, 32'h0,           1, 32'h1234AAEF, 0);
    xact(1, 0, 0, 32'h02, 4'h0, 32'h0,           1, 32'h0BADC0DE, 0);

    // Simultaneous fetch and load: load first, fetch accepted on the next IDLE edge.
    @(negedge clk);
    instruction_req = 1'b1; instruction_addr = 32'h0;
    data_read_valid = 1'b1; data_addr = 32'h10;
    @(posedge clk); #1;
    t0 = cyc;
    push(1, 1, 32'h1234AAEF, 0, t0);
    data_read_valid = 1'b0;
    push(0, 1, 32'h0BADC0DE, 0, t0 + LAT + 2);
    repeat (LAT + 2) @(posedge clk); #1;
    instruction_req = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    @(negedge clk);
    chk("fetch_read_holds", instruction_read, 32'h0BADC0DE);

    // Reset one cycle after accept, and reset on the commit edge: neither store lands.
    reset_mid(32'h20, 32'h12345678, 1, "reset_after_accept");
    reset_mid(32'h20, 32'h0F0F0F0F, LAT, "reset_on_commit");
    xact(0, 1, 0, 32'h20, 4'h0, 32'h0, 1, 32'hCAFEF00D, 0);

`ifdef MEM_BOUNDS_CHECK_EN
    xact(0, 0, 1, 32'h1000, 4'hF, 32'h55AA55AA, 1, 32'h0, 1);
    xact(0, 1, 0, 32'h1000, 4'h0, 32'h0,        1, 32'h0, 1);
    xact(0, 1, 0, 32'h0000, 4'h0, 32'h0,        1, 32'h0BADC0DE, 0);
`else
    xact(0, 0, 1, 32'h1000, 4'hF, 32'h55AA55AA, 1, 32'h0BADC0DE, 0);
    xact(0, 1, 0, 32'h0000, 4'h0, 32'h0,        1, 32'h55AA55AA, 0);
`endif

    // Load held high through DONE: back-to-back accepts one full transaction apart.
    @(negedge clk);
    data_read_valid = 1'b1; data_addr = 32'h20;
    @(posedge clk); #1;
    t0 = cyc;
    push(1, 1, 32'hCAFEF00D, 0, t0);
    push(1, 1, 32'hCAFEF00D, 0, t0 + LAT + 2);
    repeat (2 * LAT + 2) @(posedge clk);
    @(negedge clk);
    data_read_valid = 1'b0;
    repeat (LAT + 4) @(posedge clk);
    @(negedge clk);

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_responses: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
